// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - shared system bus widths and destination select encoding
// Purpose: common definitions for both ends of the system bus (source mux and
//          load end). Both ends must agree on the bus_sel_e encoding.
// Contents: N (bus width), AW (address width), DW (data register width),
//           bus_sel_e (4-bit destination/source select), is_noop_sel helper.
package sysbus_pkg;

  localparam int N  = 38;
  localparam int AW = 12;
  localparam int DW = 32;

  typedef enum logic [3:0] {
    PC   = 4'd0,
    DR   = 4'd1,
    AR   = 4'd2,
    AC   = 4'd3,
    MEM  = 4'd4,
    TR   = 4'd5,
    ROP1 = 4'd6,
    ROP2 = 4'd7,
    GPR1 = 4'd8
  } bus_sel_e;

  // Selects above GPR1 address no destination.
  function automatic logic is_noop_sel(input logic [3:0] sel);
    return sel > 4'(GPR1);
  endfunction

endpackage

// File: rtl/system_bus_load_if.sv
// rtl/system_bus_load_if.sv - control and memory-write handshake bundle of the bus load end
// Purpose: groups the bus value, control-unit strobes and the memory write
//          handshake. master = control unit / memory side, slave = load end.
// Signals: bus, ld_sel, ld_en, inc_pc, clr_ac (control -> load end);
//          mem_addr, mem_wdata, mem_we, busy (load end -> memory/control);
//          mem_ack (memory -> load end).
interface system_bus_load_if;
  import sysbus_pkg::*;

  logic [N-1:0]  bus;
  logic [3:0]    ld_sel;
  logic          ld_en;
  logic          inc_pc;
  logic          clr_ac;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_we;
  logic          mem_ack;
  logic          busy;

  modport master (
    output bus, ld_sel, ld_en, inc_pc, clr_ac, mem_ack,
    input  mem_addr, mem_wdata, mem_we, busy
  );

  modport slave (
    input  bus, ld_sel, ld_en, inc_pc, clr_ac, mem_ack,
    output mem_addr, mem_wdata, mem_we, busy
  );

endinterface

// File: rtl/system_bus_memwr.sv
// rtl/system_bus_memwr.sv - MEM destination write FSM with address/data capture
// Purpose: on start in IDLE captures data and address, raises mem_we and busy,
//          and holds them until mem_ack is sampled high.
// Ports: clk, rst (async active-high); start (MEM load request), data (bus
//        value), addr (current AR), ack (memory acknowledge); outputs
//        mem_addr, mem_wdata, mem_we, busy.
module system_bus_memwr
  import sysbus_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  data,
  input  logic [AW-1:0] addr,
  input  logic          ack,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          mem_we,
  output logic          busy
);

  // mem_wr_state_e
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0] state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // ack in IDLE is meaningless and deliberately ignored.
          if (start) begin
            mem_addr  <= addr;
            mem_wdata <= data;
            mem_we    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          // A new start here is dropped; there is no request queue.
          if (ack) begin
            mem_we <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state flop, so it tracks mem_we exactly.
  assign busy = (state == WRITE);

endmodule

// File: rtl/system_bus_load.sv
// rtl/system_bus_load.sv - destination (load) end of the CPU system bus
// Purpose: latches the bus value into the selected destination register
//          (PC, DR, AR, AC, TR, ROP1, ROP2, GPR1) or starts a memory write.
// Ports: clk, rst (async active-high); sb (system_bus_load_if.slave: bus,
//        ld_sel, ld_en, inc_pc, clr_ac, mem_ack, mem_addr, mem_wdata, mem_we,
//        busy); register outputs PC_q, AR_q, DR_q, AC_q, TR_q, ROP1_q, ROP2_q,
//        GPR1_q.
// Option: SYSBUS_LOAD_CONFLICT_EN adds a sticky 'conflict' output flagging a
//         MEM load while busy or a load with a no-op select.
module system_bus_load
  import sysbus_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  system_bus_load_if.slave sb,
  output logic [AW-1:0] PC_q,
  output logic [AW-1:0] AR_q,
  output logic [N-1:0]  DR_q,
  output logic [DW-1:0] AC_q,
  output logic [DW-1:0] TR_q,
  output logic [DW-1:0] ROP1_q,
  output logic [DW-1:0] ROP2_q,
  output logic [DW-1:0] GPR1_q
`ifdef SYSBUS_LOAD_CONFLICT_EN
  ,
  output logic          conflict
`endif
);

  logic ld_pc, ld_dr, ld_ar, ld_ac, ld_mem, ld_tr, ld_rop1, ld_rop2, ld_gpr1;

  assign ld_pc   = sb.ld_en && (sb.ld_sel == 4'(PC));
  assign ld_dr   = sb.ld_en && (sb.ld_sel == 4'(DR));
  assign ld_ar   = sb.ld_en && (sb.ld_sel == 4'(AR));
  assign ld_ac   = sb.ld_en && (sb.ld_sel == 4'(AC));
  assign ld_mem  = sb.ld_en && (sb.ld_sel == 4'(MEM));
  assign ld_tr   = sb.ld_en && (sb.ld_sel == 4'(TR));
  assign ld_rop1 = sb.ld_en && (sb.ld_sel == 4'(ROP1));
  assign ld_rop2 = sb.ld_en && (sb.ld_sel == 4'(ROP2));
  assign ld_gpr1 = sb.ld_en && (sb.ld_sel == 4'(GPR1));

  // Register bank: each destination takes the low bits of the bus that fit it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_q   <= '0;
      AR_q   <= '0;
      DR_q   <= '0;
      AC_q   <= '0;
      TR_q   <= '0;
      ROP1_q <= '0;
      ROP2_q <= '0;
      GPR1_q <= '0;
    end else begin
      // An explicit load outranks increment/clear in the same cycle.
      if (ld_pc)          PC_q <= sb.bus[AW-1:0];
      else if (sb.inc_pc) PC_q <= PC_q + AW'(1);

      if (ld_ac)          AC_q <= sb.bus[DW-1:0];
      else if (sb.clr_ac) AC_q <= '0;

      if (ld_dr)   DR_q   <= sb.bus;
      if (ld_ar)   AR_q   <= sb.bus[AW-1:0];
      if (ld_tr)   TR_q   <= sb.bus[DW-1:0];
      if (ld_rop1) ROP1_q <= sb.bus[DW-1:0];
      if (ld_rop2) ROP2_q <= sb.bus[DW-1:0];
      if (ld_gpr1) GPR1_q <= sb.bus[DW-1:0];
    end
  end

  // AR_q here is the pre-edge value, so a same-edge AR load does not leak in.
  system_bus_memwr u_memwr (
    .clk       (clk),
    .rst       (rst),
    .start     (ld_mem),
    .data      (sb.bus),
    .addr      (AR_q),
    .ack       (sb.mem_ack),
    .mem_addr  (sb.mem_addr),
    .mem_wdata (sb.mem_wdata),
    .mem_we    (sb.mem_we),
    .busy      (sb.busy)
  );

`ifdef SYSBUS_LOAD_CONFLICT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= 1'b0;
    end else if ((ld_mem && sb.busy) || (sb.ld_en && is_noop_sel(sb.ld_sel))) begin
      conflict <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_system_bus_load.sv
// tb/tb_system_bus_load.sv - self-checking bench for system_bus_load
// Purpose: directed scenarios with literal expectations plus randomized
//          traffic, all checked every cycle against a behavioural model.
// Option: honours SYSBUS_LOAD_CONFLICT_EN for the conflict output.
module tb_system_bus_load;
  import sysbus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  system_bus_load_if sb ();

  logic [AW-1:0] pc_q, ar_q;
  logic [N-1:0]  dr_q;
  logic [DW-1:0] ac_q, tr_q, rop1_q, rop2_q, gpr1_q;
`ifdef SYSBUS_LOAD_CONFLICT_EN
  logic conflict;
`endif

  system_bus_load dut (
    .clk    (clk),
    .rst    (rst),
    .sb     (sb),
    .PC_q   (pc_q),
    .AR_q   (ar_q),
    .DR_q   (dr_q),
    .AC_q   (ac_q),
    .TR_q   (tr_q),
    .ROP1_q (rop1_q),
    .ROP2_q (rop2_q),
    .GPR1_q (gpr1_q)
`ifdef SYSBUS_LOAD_CONFLICT_EN
    ,
    .conflict (conflict)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Destinations indexed by select code; index 4 (MEM) unused.
  logic [37:0] m_dst [0:8];
  bit          m_wr;
  logic [37:0] m_addr, m_data;
  bit          m_conf;

  function automatic int dst_width(input int sel);
    if (sel == 0 || sel == 2) return AW;
    if (sel == 1) return N;
    return DW;
  endfunction

  function automatic logic [37:0] keep_low(input logic [37:0] v, input int w);
    logic [38:0] m;
    m = (39'd1 << w) - 39'd1;
    return v & m[37:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) m_dst[i] = '0;
      m_wr = 0; m_addr = '0; m_data = '0; m_conf = 0;
    end else begin
      int sel;
      bit en;
      logic [37:0] nxt [0:8];
      sel = int'(sb.ld_sel);
      en  = sb.ld_en;
      for (int i = 0; i < 9; i++) nxt[i] = m_dst[i];
      if (sb.inc_pc) nxt[0] = keep_low(m_dst[0] + 38'd1, AW);
      if (sb.clr_ac) nxt[3] = '0;
      if (en && sel <= 8 && sel != 4) nxt[sel] = keep_low(sb.bus, dst_width(sel));
      if (en && ((sel == 4 && m_wr) || sel > 8)) m_conf = 1;
      if (!m_wr) begin
        if (en && sel == 4) begin
          m_wr = 1; m_addr = m_dst[2]; m_data = sb.bus;
        end
      end else if (sb.mem_ack) begin
        m_wr = 0;
      end
      for (int i = 0; i < 9; i++) m_dst[i] = nxt[i];
    end
  end

  // ---------------- compare process ----------------
  task automatic compare_all();
    chk("PC_q",      64'(pc_q),         64'(m_dst[0][AW-1:0]));
    chk("DR_q",      64'(dr_q),         64'(m_dst[1]));
    chk("AR_q",      64'(ar_q),         64'(m_dst[2][AW-1:0]));
    chk("AC_q",      64'(ac_q),         64'(m_dst[3][DW-1:0]));
    chk("TR_q",      64'(tr_q),         64'(m_dst[5][DW-1:0]));
    chk("ROP1_q",    64'(rop1_q),       64'(m_dst[6][DW-1:0]));
    chk("ROP2_q",    64'(rop2_q),       64'(m_dst[7][DW-1:0]));
    chk("GPR1_q",    64'(gpr1_q),       64'(m_dst[8][DW-1:0]));
    chk("mem_we",    64'(sb.mem_we),    64'(m_wr));
    chk("busy",      64'(sb.busy),      64'(m_wr));
    chk("mem_addr",  64'(sb.mem_addr),  64'(m_addr[AW-1:0]));
    chk("mem_wdata", 64'(sb.mem_wdata), 64'(m_data));
`ifdef SYSBUS_LOAD_CONFLICT_EN
    chk("conflict",  64'(conflict),     64'(m_conf));
`endif
  endtask

  always @(negedge clk) if (cmp_en) compare_all();

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] sel, input logic en, input logic [37:0] v);
    sb.ld_sel = sel; sb.ld_en = en; sb.bus = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sb.bus = '0; sb.ld_sel = '0; sb.ld_en = 0; sb.inc_pc = 0; sb.clr_ac = 0; sb.mem_ack = 0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    chk("rst PC", 64'(pc_q), 64'h0);
    chk("rst mem_we", 64'(sb.mem_we), 64'h0);

    // PC load with truncation
    drive(4'd0, 1, 38'h3_FFFF_FFFF); step(); drive(4'd0, 0, 38'h3_FFFF_FFFF);
    chk("lit PC FFF", 64'(pc_q), 64'hFFF);
    chk("lit AC still 0", 64'(ac_q), 64'h0);
    chk("lit AR still 0", 64'(ar_q), 64'h0);

    // AC, DR, GPR1
    drive(4'd3, 1, 38'h3_FFFF_FFFF); step();
    drive(4'd1, 1, 38'h3_FFFF_FFFF); step();
    drive(4'd8, 1, 38'h3_FFFF_FFFF); step();
    drive(4'd0, 0, '0);
    chk("lit AC", 64'(ac_q), 64'hFFFF_FFFF);
    chk("lit DR", 64'(dr_q), 64'h3_FFFF_FFFF);
    chk("lit GPR1", 64'(gpr1_q), 64'hFFFF_FFFF);

    // PC wrap, then load beats increment
    sb.inc_pc = 1; step(); sb.inc_pc = 0;
    chk("lit PC wrap", 64'(pc_q), 64'h000);
    sb.inc_pc = 1; drive(4'd0, 1, 38'h055); step(); sb.inc_pc = 0; drive(4'd0, 0, '0);
    chk("lit PC load wins", 64'(pc_q), 64'h055);

    // clr_ac vs load: load wins, then plain clear
    sb.clr_ac = 1; drive(4'd3, 1, 38'h1234); step(); drive(4'd0, 0, '0);
    chk("lit AC load wins", 64'(ac_q), 64'h1234);
    step(); sb.clr_ac = 0;
    chk("lit AC clear", 64'(ac_q), 64'h0);

    // Memory write
    drive(4'd2, 1, 38'h123); step();
    drive(4'd4, 1, 38'd4); step(); drive(4'd0, 0, '0);
    chk("lit mem_we", 64'(sb.mem_we), 64'h1);
    chk("lit busy", 64'(sb.busy), 64'h1);
    chk("lit mem_addr", 64'(sb.mem_addr), 64'h123);
    chk("lit mem_wdata", 64'(sb.mem_wdata), 64'd4);
    drive(4'd4, 1, 38'd9); step();
    drive(4'd5, 1, 38'd5); step();
    drive(4'd0, 0, '0); step();
    chk("lit wdata held", 64'(sb.mem_wdata), 64'd4);
    chk("lit we held", 64'(sb.mem_we), 64'h1);
    chk("lit TR while busy", 64'(tr_q), 64'd5);
`ifdef SYSBUS_LOAD_CONFLICT_EN
    chk("lit conflict", 64'(conflict), 64'h1);
`endif
    sb.mem_ack = 1; step(); sb.mem_ack = 0;
    chk("lit we after ack", 64'(sb.mem_we), 64'h0);
    chk("lit busy after ack", 64'(sb.busy), 64'h0);

    // Ack in IDLE ignored
    sb.mem_ack = 1; step(); sb.mem_ack = 0;
    chk("lit idle ack", 64'(sb.mem_we), 64'h0);

    // Reset in the middle of a write
    drive(4'd4, 1, 38'd7); step(); drive(4'd0, 0, '0);
    chk("lit busy 2", 64'(sb.busy), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("lit async we", 64'(sb.mem_we), 64'h0);
    chk("lit async busy", 64'(sb.busy), 64'h0);
    chk("lit async PC", 64'(pc_q), 64'h0);
    chk("lit async TR", 64'(tr_q), 64'h0);
    chk("lit async DR", 64'(dr_q), 64'h0);
    step(); rst = 1'b0;
    drive(4'd4, 1, 38'd11); step(); drive(4'd0, 0, '0);
    chk("lit fresh we", 64'(sb.mem_we), 64'h1);
    chk("lit fresh addr", 64'(sb.mem_addr), 64'h0);
    chk("lit fresh data", 64'(sb.mem_wdata), 64'd11);
    sb.mem_ack = 1; step(); sb.mem_ack = 0;
    chk("lit fresh done", 64'(sb.busy), 64'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) r = '1;
      sb.bus     = r[37:0];
      sb.ld_sel  = 4'($urandom_range(0, 15));
      sb.ld_en   = ($urandom_range(0, 3) != 0);
      sb.inc_pc  = ($urandom_range(0, 3) == 0);
      sb.clr_ac  = ($urandom_range(0, 5) == 0);
      sb.mem_ack = ($urandom_range(0, 3) == 0);
      step();
    end
    drive(4'd0, 0, '0); sb.inc_pc = 0; sb.clr_ac = 0; sb.mem_ack = 0;
    step();
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/system_bus_load.md
Name: system_bus_load

Overview:
- Destination ("load") end of the CPU system bus. The source mux drives one register's value onto the shared N-bit bus.
- This block latches the bus value into the selected destination register: PC, DR, AR, AC, TR, ROP1, ROP2 or GPR1.
- For the MEM destination it runs a registered write handshake to memory.
- Sits between the bus mux output and the control unit, which drives ld_sel/ld_en each microstep.

Parameters:
- N, 38, system bus width (full instruction/data word).
- AW, 12, address width (PC, AR, mem_addr).
- DW, 32, data register width (AC, TR, ROP1, ROP2, GPR1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus  in  N  system bus value from the source mux.
- ld_sel  in  4  destination select: 0 PC, 1 DR, 2 AR, 3 AC, 4 MEM, 5 TR, 6 ROP1, 7 ROP2, 8 GPR1, 9-15 no-op.
- ld_en  in  1  load strobe, sampled each clk.
- inc_pc  in  1  increment PC.
- clr_ac  in  1  clear AC.
- PC_q  out  AW  program counter.
- AR_q  out  AW  address register.
- DR_q  out  N  data register.
- AC_q, TR_q, ROP1_q, ROP2_q, GPR1_q  out  DW each  data registers.
- mem_addr  out  AW  write address.
- mem_wdata  out  N  write data.
- mem_we  out  1  write request.
- mem_ack  in  1  memory write acknowledge.
- busy  out  1  MEM write in progress.

Behaviour:
- Reset (async, immediate): all register outputs, mem_addr, mem_wdata, mem_we, busy = 0; FSM = IDLE.
- Register loads:
  - ld_en=1 at a rising edge with ld_sel in {0,1,2,3,5,6,7,8}: the target updates at that edge and is visible the next cycle (1-cycle latency).
  - Width rule: destination takes bus[W-1:0] of its own width (AW, DW or N); upper bits are discarded.
  - ld_sel 9-15 with ld_en: no state change.
- PC:
  - inc_pc=1: PC_q <= PC_q+1, wrapping modulo 2^AW (0xFFF -> 0x000).
  - ld_en with ld_sel=0 and inc_pc in the same cycle: the load wins.
- AC: clr_ac=1 sets AC_q <= 0; ld_en with ld_sel=3 and clr_ac in the same cycle: the load wins.
- MEM write FSM, states IDLE and WRITE:
  - IDLE + ld_en + ld_sel=4: mem_wdata <= bus, mem_addr <= AR_q (value before any same-edge AR update), mem_we <= 1, go to WRITE.
  - WRITE: hold mem_we, mem_addr and mem_wdata stable until mem_ack is sampled high. On that edge mem_we <= 0 and the FSM returns to IDLE.
  - Minimum occupancy is 1 cycle of WRITE.
  - busy = (state == WRITE), registered, asserted coincident with mem_we.
  - ld_en with ld_sel=4 while in WRITE is ignored; no queueing.
  - Loads to non-MEM destinations (including AR) proceed normally while busy.
  - mem_ack while in IDLE is ignored.
- Reset during WRITE: mem_we and busy drop asynchronously and no ack is awaited; the memory side must tolerate an aborted request.

Optional Feature:
- Macro SYSBUS_LOAD_CONFLICT_EN.
- When defined: adds output port conflict (1 bit, sticky). It is set on the edge where ld_en && ld_sel==4 && busy, or where ld_en && ld_sel in 9-15. It is cleared only by rst.
- When undefined: the port is absent and these events are silently ignored as described above.

Decomposition:
- Shared package sysbus_pkg, also imported by the source mux: parameters N/AW/DW, and enum bus_sel_e (PC=0 ... GPR1=8) with 4-bit encoding. Both ends must use the same encoding.
- FSM state enum mem_wr_state_e {IDLE, WRITE} is local to this block.
- One sub-module: system_bus_memwr, containing the MEM write FSM, address/data capture and busy.
- Register bank stays in the top module.

Test Plan:
- Reset then bus=38'h3_FFFF_FFFF, ld_sel=0, ld_en pulse -> PC_q=12'hFFF next cycle; other outputs remain 0.
- Same bus value loaded to AC (3), DR (1) and GPR1 (8) -> AC_q=32'hFFFF_FFFF, DR_q=38'h3_FFFF_FFFF, GPR1_q=32'hFFFF_FFFF (truncation check).
- PC_q=12'hFFF, inc_pc=1 -> PC_q=12'h000. Then inc_pc=1 together with ld_en, ld_sel=0, bus=12'h055 -> PC_q=12'h055.
- AR loaded 12'h123; then bus=38'd4, ld_sel=4 pulse:
  - mem_we=1, busy=1, mem_addr=12'h123, mem_wdata=38'd4 next cycle.
  - mem_ack held low 3 cycles -> outputs stable.
  - ack high 1 cycle -> mem_we=0, busy=0 after that edge.
- During WRITE: second ld_sel=4 pulse with bus=38'd9 -> mem_wdata stays 38'd4 (conflict=1 if SYSBUS_LOAD_CONFLICT_EN). Concurrent ld_sel=5 with bus=32'd5 -> TR_q=5.
- rst asserted mid-WRITE between clock edges -> mem_we, busy and all registers become 0 immediately. After release, ld_sel=4 starts a fresh write normally.
